// File: rtl/tree_root_sequencer.sv
// tree_root_sequencer: walks the top node of a sort tree through reset, center
// fill, sort-axis configuration and sorting, buffering host center words in a
// small FIFO while idle.
// Optional feature: define TREE_ROOT_SEQUENCER_WATCHDOG_EN to enable a per-state
// watchdog that abandons a run stuck waiting on the node for TIMEOUT cycles.
module tree_root_sequencer #(
  parameter int DATA_W     = 24,
  parameter int CMD_W      = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] center_in,
  input  logic              center_valid,
  output logic              center_ready,
  input  logic [1:0]        axis_in,
  input  logic              start,
  output logic [CMD_W-1:0]  command_to_node,
  output logic [DATA_W-1:0] data_to_node,
  input  logic [CMD_W-1:0]  command_from_node,
  input  logic [DATA_W-1:0] data_from_node,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] root_center,
  output logic              underflow,
  output logic              timeout
);

  localparam logic [CMD_W-1:0] CMD_NOP        = CMD_W'(5'h00);
  localparam logic [CMD_W-1:0] CMD_RST        = CMD_W'(5'h1f);
  localparam logic [CMD_W-1:0] CMD_RST_DONE   = CMD_W'(5'h1e);
  localparam logic [CMD_W-1:0] CMD_FILL       = CMD_W'(5'h01);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE  = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CMD_CFG        = CMD_W'(5'h02);
  localparam logic [CMD_W-1:0] CMD_CFG_DONE   = CMD_W'(5'h07);
  localparam logic [CMD_W-1:0] CMD_SORT       = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] CMD_VALID_SORT = CMD_W'(5'h0f);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_FILL, S_GAP1, S_CFG, S_GAP2, S_SORT, S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_axis;
  logic [CMD_W-1:0]    r_cmd;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_rootCenter;
  logic                r_busy;
  logic                r_done;
  logic                r_underflow;
  logic                r_timeout;

  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [CNT_W-1:0]    r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_fillStep;
  logic                w_pop;
  logic                w_flush;
  logic                w_wdFire;
  logic [DATA_W-1:0]   w_fillData;
  logic [DATA_W-1:0]   w_axisWord;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign center_ready = !w_full && (r_state == S_IDLE);
  assign w_push       = center_valid && center_ready;

  // A fill word goes out on the edge leaving RST and on every FILL edge that
  // does not see the node's fill acknowledgement.
  assign w_fillStep = !w_wdFire &&
                      (((r_state == S_RST)  && (command_from_node == CMD_RST_DONE)) ||
                       ((r_state == S_FILL) && (command_from_node != CMD_FILL_DONE)));
  assign w_pop      = w_fillStep && !w_empty;
  assign w_flush    = ((r_state == S_FILL) && (command_from_node == CMD_FILL_DONE)) || w_wdFire;
  assign w_fillData = w_empty ? '0 : r_fifo[r_rdPtr];
  assign w_axisWord = {{(DATA_W-2){1'b0}}, r_axis};

`ifdef TREE_ROOT_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdCnt;
  logic            w_watched;
  logic            w_exit;

  // Identify the waiting states and the node answer that lets each one move on.
  always_comb begin
    w_watched = 1'b0;
    w_exit    = 1'b0;
    case (r_state)
      S_RST:  begin w_watched = 1'b1; w_exit = (command_from_node == CMD_RST_DONE);   end
      S_FILL: begin w_watched = 1'b1; w_exit = (command_from_node == CMD_FILL_DONE);  end
      S_CFG:  begin w_watched = 1'b1; w_exit = (command_from_node == CMD_CFG_DONE);   end
      S_SORT: begin w_watched = 1'b1; w_exit = (command_from_node == CMD_VALID_SORT); end
      default: ;
    endcase
  end

  assign w_wdFire = w_watched && !w_exit && (r_wdCnt >= WD_W'(TIMEOUT - 1));

  // Count cycles spent in the current waiting state; every state entry starts at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdCnt <= '0;
    end else if (!w_watched || w_exit) begin
      r_wdCnt <= '0;
    end else begin
      r_wdCnt <= r_wdCnt + 1'b1;
    end
  end
`else
  // Without the watchdog the states wait on the node forever; TIMEOUT has no effect.
  assign w_wdFire = 1'b0 && (TIMEOUT > 0);
`endif

  // FIFO storage: written only while idle, so no reset is needed on the array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= center_in;
    end
  end

  // FIFO pointers and occupancy; a flush discards whatever the run did not consume.
  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sequencer FSM; command/data registers hold what the node sees next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_axis       <= '0;
      r_cmd        <= CMD_NOP;
      r_data       <= '0;
      r_rootCenter <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underflow  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wdFire) begin
        r_state   <= S_IDLE;
        r_cmd     <= CMD_NOP;
        r_data    <= '0;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cmd  <= CMD_NOP;
            r_data <= '0;
            r_busy <= 1'b0;
            if (start && !w_empty) begin
              r_state     <= S_RST;
              r_axis      <= axis_in;
              r_underflow <= 1'b0;
              r_timeout   <= 1'b0;
              r_cmd       <= CMD_RST;
              r_busy      <= 1'b1;
            end
          end
          S_RST: begin
            if (command_from_node == CMD_RST_DONE) begin
              r_state <= S_FILL;
              r_cmd   <= CMD_FILL;
              r_data  <= w_fillData;
              if (w_empty) begin
                r_underflow <= 1'b1;
              end
            end else begin
              r_cmd  <= CMD_RST;
              r_data <= '0;
            end
          end
          S_FILL: begin
            if (command_from_node == CMD_FILL_DONE) begin
              r_state <= S_GAP1;
              r_cmd   <= CMD_NOP;
              r_data  <= '0;
            end else begin
              r_cmd  <= CMD_FILL;
              r_data <= w_fillData;
              if (w_empty) begin
                r_underflow <= 1'b1;
              end
            end
          end
          S_GAP1: begin
            r_state <= S_CFG;
            r_cmd   <= CMD_CFG;
            r_data  <= w_axisWord;
          end
          S_CFG: begin
            if (command_from_node == CMD_CFG_DONE) begin
              r_state <= S_GAP2;
              r_cmd   <= CMD_NOP;
              r_data  <= '0;
            end else begin
              r_cmd  <= CMD_CFG;
              r_data <= w_axisWord;
            end
          end
          S_GAP2: begin
            r_state <= S_SORT;
            r_cmd   <= CMD_SORT;
            r_data  <= w_axisWord;
          end
          S_SORT: begin
            if (command_from_node == CMD_VALID_SORT) begin
              r_state      <= S_DONE;
              r_rootCenter <= data_from_node;
              r_cmd        <= CMD_NOP;
              r_data       <= '0;
              r_done       <= 1'b1;
            end else begin
              r_cmd  <= CMD_SORT;
              r_data <= w_axisWord;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_NOP;
            r_data  <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_NOP;
            r_data  <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign command_to_node = r_cmd;
  assign data_to_node    = r_data;
  assign root_center     = r_rootCenter;
  assign busy            = r_busy;
  assign done            = r_done;
  assign underflow       = r_underflow;
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_tree_root_sequencer.sv
// tb_tree_root_sequencer: randomized and directed runs of tree_root_sequencer
// against a behavioural node model and a queue-based scoreboard.
// Watchdog expectations follow TREE_ROOT_SEQUENCER_WATCHDOG_EN.
module tb_tree_root_sequencer;

  localparam int DATA_W = 24;
  localparam int CMD_W  = 5;
  localparam int DEPTH  = 16;
  localparam int TMO    = 64;

  localparam logic [4:0] NOP        = 5'h00;
  localparam logic [4:0] RST        = 5'h1f;
  localparam logic [4:0] RST_DONE   = 5'h1e;
  localparam logic [4:0] FILL       = 5'h01;
  localparam logic [4:0] FILL_DONE  = 5'h05;
  localparam logic [4:0] CFG        = 5'h02;
  localparam logic [4:0] CFG_DONE   = 5'h07;
  localparam logic [4:0] SORT       = 5'h09;
  localparam logic [4:0] VALID_SORT = 5'h0f;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] center_in;
  logic              center_valid;
  logic              center_ready;
  logic [1:0]        axis_in;
  logic              start;
  logic [CMD_W-1:0]  command_to_node;
  logic [DATA_W-1:0] data_to_node;
  logic [CMD_W-1:0]  command_from_node;
  logic [DATA_W-1:0] data_from_node;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] root_center;
  logic              underflow;
  logic              timeout;

  tree_root_sequencer #(
    .DATA_W(DATA_W), .CMD_W(CMD_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .center_in(center_in), .center_valid(center_valid), .center_ready(center_ready),
    .axis_in(axis_in), .start(start),
    .command_to_node(command_to_node), .data_to_node(data_to_node),
    .command_from_node(command_from_node), .data_from_node(data_from_node),
    .busy(busy), .done(done), .root_center(root_center),
    .underflow(underflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] root;
    logic              uf;
  } exp_t;

  logic [DATA_W-1:0] modelFifo [$];
  logic [DATA_W-1:0] expFill [$];
  exp_t              expDone [$];
  logic [1:0]        runAxis;

  int errors = 0;
  int checks = 0;

  int                nodeRstLat  = 2;
  int                nodeFillLen = 1;
  int                nodeCfgLat  = 1;
  int                nodeSortLat = 1;
  logic [DATA_W-1:0] nodeSortData = '0;
  bit                nodeStall = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Node model: answers each command after a programmed number of visible cycles.
  logic [CMD_W-1:0] prevCmd = NOP;
  int               cmdCnt  = 0;
  always @(negedge clk) begin
    if (command_to_node != prevCmd) cmdCnt = 1;
    else cmdCnt++;
    prevCmd = command_to_node;
    command_from_node = NOP;
    data_from_node    = DATA_W'($urandom);
    case (command_to_node)
      RST:  if (!nodeStall && cmdCnt >= nodeRstLat) command_from_node = RST_DONE;
      FILL: if (cmdCnt >= nodeFillLen) command_from_node = FILL_DONE;
      CFG:  if (cmdCnt >= nodeCfgLat) command_from_node = CFG_DONE;
      SORT: if (cmdCnt >= nodeSortLat) begin
              command_from_node = VALID_SORT;
              data_from_node    = nodeSortData;
            end
      default: ;
    endcase
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      if (command_to_node == FILL) begin
        checkOutput("fill_data", 32'(data_to_node),
                    (expFill.size() > 0) ? 32'(expFill.pop_front()) : 32'h0);
      end
      if (command_to_node == CFG) checkOutput("cfg_data", 32'(data_to_node), 32'(runAxis));
      if (command_to_node == SORT) checkOutput("sort_data", 32'(data_to_node), 32'(runAxis));
      if (done) begin
        if (expDone.size() == 0) begin
          checkOutput("done_unexpected", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = expDone.pop_front();
          checkOutput("root_center", 32'(root_center), 32'(e.root));
          checkOutput("underflow", 32'(underflow), 32'(e.uf));
          checkOutput("timeout_at_done", 32'(timeout), 32'h0);
          checkOutput("busy_at_done", 32'(busy), 32'h1);
        end
        expFill.delete();
      end
    end
  end

  // Push one center word; the model decides whether the DUT must accept it.
  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    bit expReady;
    center_in    = d;
    center_valid = 1'b1;
    expReady     = (modelFifo.size() < DEPTH);
    checkOutput("center_ready", 32'(center_ready), 32'(expReady));
    if (expReady) modelFifo.push_back(d);
    @(negedge clk);
    center_valid = 1'b0;
  endtask

  task automatic launchRun(input int fillLen, input logic [1:0] axis, input logic [DATA_W-1:0] sortData,
                           input int rLat, input int cLat, input int sLat);
    exp_t e;
    nodeRstLat   = rLat;
    nodeFillLen  = fillLen;
    nodeCfgLat   = cLat;
    nodeSortLat  = sLat;
    nodeSortData = sortData;
    e.root = sortData;
    e.uf   = (fillLen > modelFifo.size());
    expFill.delete();
    foreach (modelFifo[i]) expFill.push_back(modelFifo[i]);
    modelFifo.delete();
    expDone.push_back(e);
    runAxis = axis;
    start   = 1'b1;
    axis_in = axis;
    @(negedge clk);
    start   = 1'b0;
    axis_in = 2'($urandom);
  endtask

  task automatic waitDone();
    bit seen = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checkOutput("done_wait", 32'h0, 32'h1);
    end else begin
      @(negedge clk);
      checkOutput("busy_after_done", 32'(busy), 32'h0);
      checkOutput("done_one_cycle", 32'(done), 32'h0);
    end
  endtask

  task automatic checkIdleEmpty(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_cmd"}, 32'(command_to_node), 32'(NOP));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    rst = 1'b0; center_in = '0; center_valid = 1'b0; axis_in = '0; start = 1'b0;
    command_from_node = NOP; data_from_node = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd", 32'(command_to_node), 32'(NOP));
    checkOutput("rst_data", 32'(data_to_node), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_root", 32'(root_center), 32'h0);
    checkOutput("rst_underflow", 32'(underflow), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(center_ready), 32'h1);
    checkIdleEmpty("empty_start");

    applyStimulus(24'h010203);
    applyStimulus(24'h040506);
    applyStimulus(24'h070809);
    launchRun(3, 2'd1, 24'h040506, 2, 2, 3);
    waitDone();

    applyStimulus(24'hABCDEF);
    launchRun(4, 2'd2, 24'h123456, 1, 1, 1);
    waitDone();

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(DATA_W'($urandom));
    launchRun(DEPTH, 2'd3, DATA_W'($urandom), 3, 1, 2);
    waitDone();

    for (int i = 0; i < 5; i++) applyStimulus(DATA_W'($urandom));
    launchRun(2, 2'd0, DATA_W'($urandom), 1, 3, 1);
    waitDone();

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) applyStimulus(DATA_W'($urandom));
      launchRun($urandom_range(1, n + 2), 2'($urandom), DATA_W'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
      waitDone();
    end

    applyStimulus(DATA_W'($urandom));
    applyStimulus(DATA_W'($urandom));
    launchRun(3, 2'd2, DATA_W'($urandom), 2, 1, 1000);
    begin
      bit inSort = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (command_to_node == SORT) begin
          inSort = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput("reach_sort", 32'(inSort), 32'h1);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrun_cmd", 32'(command_to_node), 32'(NOP));
    checkOutput("midrun_busy", 32'(busy), 32'h0);
    checkOutput("midrun_underflow", 32'(underflow), 32'h0);
    checkOutput("midrun_root", 32'(root_center), 32'h0);
    checkOutput("midrun_done", 32'(done), 32'h0);
    rst = 1'b1;
    expDone.delete();
    expFill.delete();
    nodeSortLat = 1;
    @(negedge clk);
    checkIdleEmpty("midrun_fifo");

    nodeStall = 1'b1;
    applyStimulus(DATA_W'($urandom));
    launchRun(1, 2'd1, DATA_W'($urandom), 2, 1, 1);
`ifdef TREE_ROOT_SEQUENCER_WATCHDOG_EN
    begin
      bit fired = 1'b0;
      for (int c = 0; c < 4 * TMO; c++) begin
        if (timeout) begin
          fired = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput("wd_timeout", 32'(fired), 32'h1);
      checkOutput("wd_busy", 32'(busy), 32'h0);
      checkOutput("wd_cmd", 32'(command_to_node), 32'(NOP));
    end
    expDone.delete();
    expFill.delete();
    nodeStall = 1'b0;
    checkIdleEmpty("wd_fifo");
`else
    repeat (3 * TMO) @(negedge clk);
    checkOutput("stall_busy", 32'(busy), 32'h1);
    checkOutput("stall_cmd", 32'(command_to_node), 32'(RST));
    checkOutput("stall_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expDone.delete();
    expFill.delete();
    nodeStall = 1'b0;
    @(negedge clk);
`endif
    checkOutput("scoreboard_drained", 32'(expDone.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
